// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: CPU fetch/data ports and memory req/ack bus seen by mem_port_arbiter.
interface mem_port_arbiter_if;
    logic        if_req, if_ready;
    logic [31:0] if_addr, if_rdata;
    logic        d_read, d_ready;
    logic [3:0]  d_we;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_ack;
    logic [3:0]  mem_write;
    logic        cpu_stall, bus_err;
    modport slave (
        input  if_req, if_addr, d_read, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, d_rdata, d_ready, mem_addr, mem_read, mem_write, mem_wdata,
               cpu_stall, bus_err
    );
    modport master (
        output if_req, if_addr, d_read, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, d_rdata, d_ready, mem_addr, mem_read, mem_write, mem_wdata,
               cpu_stall, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin fetch/data arbiter onto one req/ack memory; MEM_TIMEOUT_EN adds a BUSY timeout.
module mem_port_arbiter #(
    parameter int TIMEOUT_CYC = 255
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, BUSY_IF, BUSY_D, RESP, DONE} state_t;
    state_t      state, state_n;
    logic        last_d, last_d_n;
    logic [31:0] addr_n, wdata_n, if_rdata_n, d_rdata_n;
    logic [3:0]  write_n;
    logic        read_n, if_ready_n, d_ready_n;
    logic        d_req, pick_d, busy, timeout;
    assign d_req = bus.d_read | (|bus.d_we);
    assign pick_d = d_req & (~bus.if_req | ~last_d);
    assign busy = (state == BUSY_IF) | (state == BUSY_D);
    assign bus.cpu_stall = (bus.if_req & ~bus.if_ready) | (d_req & ~bus.d_ready);
`ifdef MEM_TIMEOUT_EN
    logic [7:0] cnt;
    assign timeout = busy & ~bus.mem_ack & (cnt == 8'(TIMEOUT_CYC - 1));
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt <= '0;
            bus.bus_err <= 1'b0;
        end else begin
            cnt <= (busy & ~bus.mem_ack) ? cnt + 8'd1 : 8'd0;
            bus.bus_err <= bus.bus_err | timeout;
        end
`else
    logic [7:0] unused_cyc;
    assign unused_cyc = 8'(TIMEOUT_CYC);
    assign timeout = 1'b0;
    assign bus.bus_err = 1'b0;
`endif
    always_comb begin
        state_n = state;
        last_d_n = last_d;
        addr_n = bus.mem_addr;
        read_n = bus.mem_read;
        write_n = bus.mem_write;
        wdata_n = bus.mem_wdata;
        if_rdata_n = bus.if_rdata;
        d_rdata_n = bus.d_rdata;
        if_ready_n = 1'b0;
        d_ready_n = 1'b0;
        case (state)
            IDLE: if (bus.if_req | d_req) begin
                state_n = pick_d ? BUSY_D : BUSY_IF;
                last_d_n = pick_d;
                addr_n = pick_d ? bus.d_addr : bus.if_addr;
                read_n = pick_d ? ~|bus.d_we : 1'b1;
                write_n = pick_d ? bus.d_we : 4'd0;
                wdata_n = pick_d ? bus.d_wdata : 32'd0;
            end
            BUSY_IF, BUSY_D: if (bus.mem_ack | timeout) begin
                // timeout only fires without ack, so ack always takes priority
                state_n = RESP;
                read_n = 1'b0;
                write_n = 4'd0;
                addr_n = timeout ? 32'd0 : bus.mem_addr;
                wdata_n = timeout ? 32'd0 : bus.mem_wdata;
                if_ready_n = state == BUSY_IF;
                d_ready_n = state == BUSY_D;
                if (state == BUSY_IF) if_rdata_n = timeout ? 32'hDEAD_BEEF : bus.mem_rdata;
                else if (bus.mem_read | timeout) d_rdata_n = timeout ? 32'hDEAD_BEEF : bus.mem_rdata;
            end
            RESP: state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            last_d <= 1'b1;
            bus.mem_addr <= '0;
            bus.mem_read <= 1'b0;
            bus.mem_write <= '0;
            bus.mem_wdata <= '0;
            bus.if_rdata <= '0;
            bus.d_rdata <= '0;
            bus.if_ready <= 1'b0;
            bus.d_ready <= 1'b0;
        end else begin
            state <= state_n;
            last_d <= last_d_n;
            bus.mem_addr <= addr_n;
            bus.mem_read <= read_n;
            bus.mem_write <= write_n;
            bus.mem_wdata <= wdata_n;
            bus.if_rdata <= if_rdata_n;
            bus.d_rdata <= d_rdata_n;
            bus.if_ready <= if_ready_n;
            bus.d_ready <= d_ready_n;
        end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic auto_ack = 1'b0;
    logic man_ack = 1'b0;
    int checks = 0;
    int errors = 0;
    mem_port_arbiter_if bus();
    mem_port_arbiter #(.TIMEOUT_CYC(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // auto_ack answers in the first BUSY cycle (zero-latency memory)
    assign bus.mem_ack = auto_ack ? (bus.mem_read | (|bus.mem_write)) : man_ack;

    task automatic clear_inputs;
        bus.if_req = 0; bus.if_addr = 0; bus.d_read = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0;
        auto_ack = 0; man_ack = 0;
    endtask

    task automatic hold_reset;
        rst = 1;
        clear_inputs();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        hold_reset();
        checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_read, bus.mem_write} !== 69'd0) begin errors++; $display("FAIL reset_mem got %h %h %b %b want 0", bus.mem_addr, bus.mem_wdata, bus.mem_read, bus.mem_write); end
        checks++; if ({bus.if_ready, bus.d_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b%b want 00", bus.if_ready, bus.d_ready); end
        checks++; if ({bus.if_rdata, bus.d_rdata} !== 64'd0) begin errors++; $display("FAIL reset_rdata got %h %h want 0", bus.if_rdata, bus.d_rdata); end
        checks++; if ({bus.bus_err, bus.cpu_stall} !== 2'b00) begin errors++; $display("FAIL reset_err_stall got %b%b want 00", bus.bus_err, bus.cpu_stall); end
        bus.if_req = 1; bus.if_addr = 32'h100;
        @(negedge clk);
        checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL reset_no_grant got %b want 0", bus.mem_read); end
        checks++; if (bus.cpu_stall !== 1'b1) begin errors++; $display("FAIL reset_stall got %b want 1", bus.cpu_stall); end
        rst = 0;
    endtask

    task automatic test_fetch;
        @(negedge clk);
        checks++; if ({bus.mem_read, bus.mem_write, bus.mem_addr} !== {1'b1, 4'd0, 32'h100}) begin errors++; $display("FAIL fetch_grant got %b %b %h want 1 0 100", bus.mem_read, bus.mem_write, bus.mem_addr); end
        checks++; if (bus.cpu_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall got %b want 1", bus.cpu_stall); end
        @(negedge clk);
        checks++; if ({bus.mem_read, bus.mem_addr, bus.if_ready} !== {1'b1, 32'h100, 1'b0}) begin errors++; $display("FAIL fetch_hold got %b %h %b want 1 100 0", bus.mem_read, bus.mem_addr, bus.if_ready); end
        man_ack = 1; bus.mem_rdata = 32'h0050_0093;
        @(negedge clk);
        man_ack = 0; bus.mem_rdata = 32'h0;
        checks++; if ({bus.if_ready, bus.if_rdata} !== {1'b1, 32'h0050_0093}) begin errors++; $display("FAIL fetch_ready got %b %h want 1 00500093", bus.if_ready, bus.if_rdata); end
        checks++; if ({bus.mem_read, bus.cpu_stall, bus.d_ready} !== 3'b000) begin errors++; $display("FAIL fetch_release got %b%b%b want 000", bus.mem_read, bus.cpu_stall, bus.d_ready); end
        bus.if_req = 0;
        @(negedge clk);
        checks++; if ({bus.if_ready, bus.if_rdata} !== {1'b0, 32'h0050_0093}) begin errors++; $display("FAIL fetch_done got %b %h want 0 00500093", bus.if_ready, bus.if_rdata); end
        @(negedge clk);
    endtask

    task automatic test_store;
        bus.d_we = 4'b0011; bus.d_read = 1; bus.d_addr = 32'h2004; bus.d_wdata = 32'hA5A5_1234;
        @(negedge clk);
        checks++; if ({bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata} !== {4'b0011, 1'b0, 32'h2004, 32'hA5A5_1234}) begin errors++; $display("FAIL store_grant got %b %b %h %h want 0011 0 2004 a5a51234", bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata); end
        @(negedge clk);
        checks++; if ({bus.mem_write, bus.mem_wdata, bus.d_ready} !== {4'b0011, 32'hA5A5_1234, 1'b0}) begin errors++; $display("FAIL store_hold got %b %h %b want 0011 a5a51234 0", bus.mem_write, bus.mem_wdata, bus.d_ready); end
        man_ack = 1; bus.mem_rdata = 32'h1234_5678;
        @(negedge clk);
        man_ack = 0;
        checks++; if ({bus.d_ready, bus.d_rdata, bus.mem_write} !== {1'b1, 32'h0, 4'd0}) begin errors++; $display("FAIL store_ready got %b %h %b want 1 00000000 0000", bus.d_ready, bus.d_rdata, bus.mem_write); end
        clear_inputs();
        @(negedge clk);
        checks++; if (bus.d_ready !== 1'b0) begin errors++; $display("FAIL store_pulse got %b want 0", bus.d_ready); end
        @(negedge clk);
    endtask

    task automatic test_load;
        bus.d_read = 1; bus.d_addr = 32'h3000;
        @(negedge clk);
        checks++; if ({bus.mem_read, bus.mem_write, bus.mem_addr} !== {1'b1, 4'd0, 32'h3000}) begin errors++; $display("FAIL load_grant got %b %b %h want 1 0 3000", bus.mem_read, bus.mem_write, bus.mem_addr); end
        man_ack = 1; bus.mem_rdata = 32'hCAFE_0001;
        @(negedge clk);
        clear_inputs();
        checks++; if ({bus.d_ready, bus.d_rdata, bus.if_ready} !== {1'b1, 32'hCAFE_0001, 1'b0}) begin errors++; $display("FAIL load_ready got %b %h %b want 1 cafe0001 0", bus.d_ready, bus.d_rdata, bus.if_ready); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_addr [4];
        exp_addr[0] = 32'h400; exp_addr[1] = 32'h800; exp_addr[2] = 32'h400; exp_addr[3] = 32'h800;
        hold_reset();
        bus.if_req = 1; bus.if_addr = 32'h400; bus.d_read = 1; bus.d_addr = 32'h800;
        bus.mem_rdata = 32'h1111_2222; auto_ack = 1;
        rst = 0;
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            checks++; if ({bus.mem_read, bus.mem_addr} !== {1'b1, exp_addr[g]}) begin errors++; $display("FAIL b2b_grant%0d got %b %h want 1 %h", g, bus.mem_read, bus.mem_addr, exp_addr[g]); end
            @(negedge clk);
            checks++; if ({bus.if_ready, bus.d_ready} !== ((g % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL b2b_ready%0d got %b%b want %b", g, bus.if_ready, bus.d_ready, (g % 2 == 0) ? 2'b10 : 2'b01); end
            repeat (2) @(negedge clk);
            checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL b2b_gap%0d got %b want 0", g, bus.mem_read); end
        end
        clear_inputs();
    endtask

    task automatic test_reset_busy;
        hold_reset();
        bus.d_we = 4'hF; bus.d_addr = 32'h2008; bus.d_wdata = 32'h5555_AAAA;
        rst = 0;
        repeat (2) @(negedge clk);
        checks++; if (bus.mem_write !== 4'hF) begin errors++; $display("FAIL rstbusy_write got %b want 1111", bus.mem_write); end
        #2 rst = 1;
        #1;
        checks++; if (bus.mem_write !== 4'h0) begin errors++; $display("FAIL rstbusy_async got %b want 0000", bus.mem_write); end
        clear_inputs();
        @(negedge clk);
        rst = 0;
        repeat (2) begin
            @(negedge clk);
            checks++; if ({bus.d_ready, bus.mem_write} !== 5'd0) begin errors++; $display("FAIL rstbusy_noready got %b %b want 0 0000", bus.d_ready, bus.mem_write); end
        end
        bus.if_req = 1; bus.if_addr = 32'h600; auto_ack = 1;
        @(negedge clk);
        checks++; if ({bus.mem_read, bus.mem_addr} !== {1'b1, 32'h600}) begin errors++; $display("FAIL rstbusy_idle got %b %h want 1 600", bus.mem_read, bus.mem_addr); end
        @(negedge clk);
        clear_inputs();
        repeat (2) @(negedge clk);
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout;
        hold_reset();
        bus.if_req = 1; bus.if_addr = 32'h500;
        rst = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++; if ({bus.mem_read, bus.if_ready, bus.bus_err} !== 3'b100) begin errors++; $display("FAIL timeout_busy%0d got %b%b%b want 100", c, bus.mem_read, bus.if_ready, bus.bus_err); end
        end
        @(negedge clk);
        checks++; if ({bus.if_ready, bus.if_rdata, bus.bus_err, bus.mem_read} !== {1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0}) begin errors++; $display("FAIL timeout_abort got %b %h %b %b want 1 deadbeef 1 0", bus.if_ready, bus.if_rdata, bus.bus_err, bus.mem_read); end
        clear_inputs();
        repeat (4) @(negedge clk);
        checks++; if ({bus.bus_err, bus.if_ready} !== 2'b10) begin errors++; $display("FAIL timeout_sticky got %b%b want 10", bus.bus_err, bus.if_ready); end
        hold_reset();
        checks++; if (bus.bus_err !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b want 0", bus.bus_err); end
        rst = 0;
    endtask
`else
    task automatic test_no_timeout;
        hold_reset();
        bus.if_req = 1; bus.if_addr = 32'h500;
        rst = 0;
        repeat (300) @(negedge clk);
        checks++; if ({bus.mem_read, bus.if_ready, bus.bus_err} !== 3'b100) begin errors++; $display("FAIL notimeout_wait got %b%b%b want 100", bus.mem_read, bus.if_ready, bus.bus_err); end
        man_ack = 1; bus.mem_rdata = 32'h7777_0000;
        @(negedge clk);
        clear_inputs();
        checks++; if ({bus.if_ready, bus.if_rdata, bus.bus_err} !== {1'b1, 32'h7777_0000, 1'b0}) begin errors++; $display("FAIL notimeout_ack got %b %h %b want 1 77770000 0", bus.if_ready, bus.if_rdata, bus.bus_err); end
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_load();
        test_back_to_back();
        test_reset_busy();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
